conv_ctrl_fsm_p: RTL

Parametrised convolver controller, successor to the fixed 9-tap controller. It sequences operand loads and MAC enables over KTAPS kernel taps × NCH input channels for each output pixel. It then waits out the MAC pipeline, writes one result to the output RAM at an auto-incremented address, and repeats for NOUT pixels before signalling end-of-convolution. It sits between the index/load unit, the MAC array and the output RAM; tap, channel and pixel counting are internal.

---
 rtl/conv_ctrl_pkg.sv | 20 ++
 rtl/conv_tap_counter.sv | 41 ++++
 rtl/conv_ctrl_fsm_p.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/conv_ctrl_pkg.sv
// rtl/conv_ctrl_pkg.sv - shared state type and width helper for the convolver controller
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    SAVE  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Counters sized for a single value still need one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/conv_tap_counter.sv
// rtl/conv_tap_counter.sv - nested tap/channel operand counter
module conv_tap_counter
  import conv_ctrl_pkg::*;
#(
  parameter int KTAPS = 9,
  parameter int NCH   = 1,
  localparam int TAP_W = clog2_min1(KTAPS),
  localparam int CH_W  = clog2_min1(NCH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             inc,
  output logic [TAP_W-1:0] tap_idx,
  output logic [CH_W-1:0]  ch_idx,
  output logic             last
);

  logic tap_wrap;
  logic ch_wrap;

  assign tap_wrap = (tap_idx == TAP_W'(KTAPS - 1));
  assign ch_wrap  = (ch_idx == CH_W'(NCH - 1));
  assign last     = tap_wrap && ch_wrap;

  // Taps are the inner loop; the last operand wraps both back to zero.
  always_ff @(posedge CLK) begin
    if (!RST || clr) begin
      tap_idx <= '0;
      ch_idx  <= '0;
    end else if (inc) begin
      if (tap_wrap) begin
        tap_idx <= '0;
        ch_idx  <= ch_wrap ? '0 : ch_idx + 1'b1;
      end else begin
        tap_idx <= tap_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_ctrl_fsm_p.sv
// rtl/conv_ctrl_fsm_p.sv - parametrised convolver controller: load/MAC sequencing, drain, result write
module conv_ctrl_fsm_p
  import conv_ctrl_pkg::*;
#(
  parameter int KTAPS    = 9,
  parameter int NCH      = 1,
  parameter int NOUT     = 16,
  parameter int PIPE_LAT = 1,
  localparam int TAP_W  = clog2_min1(KTAPS),
  localparam int CH_W   = clog2_min1(NCH),
  localparam int ADDR_W = clog2_min1(NOUT)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              abort,
  input  logic              load_done,
  output logic              index_start,
  output logic              mac_en,
  output logic              mac_clr,
  output logic [TAP_W-1:0]  tap_idx,
  output logic [CH_W-1:0]   ch_idx,
  output logic              ram_en,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              busy,
  output logic              eoc
);

  localparam int DR_W = clog2_min1((PIPE_LAT > 0) ? PIPE_LAT : 1);

  state_t            state;
  state_t            next_state;
  logic [DR_W-1:0]   drain_cnt;
  logic [ADDR_W-1:0] pix_idx;
  logic              last_op;
  logic              last_pix;
  logic              drain_done;
  logic              index_start_d;
  logic              mac_en_d;
  logic              mac_clr_d;
  logic              ram_en_d;
  logic              busy_d;
  logic              eoc_d;

  conv_tap_counter #(
    .KTAPS (KTAPS),
    .NCH   (NCH)
  ) u_tap_counter (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (abort),
    .inc     (state == MAC),
    .tap_idx (tap_idx),
    .ch_idx  (ch_idx),
    .last    (last_op)
  );

  assign last_pix   = (pix_idx == ADDR_W'(NOUT - 1));
  assign drain_done = (drain_cnt == DR_W'(PIPE_LAT - 1));
  assign ram_addr   = pix_idx;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Outputs are decoded from the next state and registered, so each one
  // lines up with the cycle its state is occupied.
  always_comb begin
    next_state    = state;
    index_start_d = 1'b0;
    mac_en_d      = 1'b0;
    mac_clr_d     = 1'b0;
    ram_en_d      = 1'b0;
    busy_d        = 1'b0;
    eoc_d         = 1'b0;

    case (state)
      IDLE:  if (start) next_state = LOAD;
      LOAD:  if (load_done) next_state = MAC;
      MAC: begin
        if (!last_op)           next_state = LOAD;
        else if (PIPE_LAT == 0) next_state = SAVE;
        else                    next_state = DRAIN;
      end
      DRAIN: if (drain_done) next_state = SAVE;
      SAVE:  next_state = last_pix ? DONE : LOAD;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase

    if (abort) next_state = IDLE;

    index_start_d = (next_state == LOAD) && (state != LOAD);
    mac_en_d      = (next_state == MAC);
    mac_clr_d     = (next_state == MAC) && (tap_idx == '0) && (ch_idx == '0);
    ram_en_d      = (next_state == SAVE);
    eoc_d         = (next_state == DONE);
    busy_d        = (next_state != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      index_start <= 1'b0;
      mac_en      <= 1'b0;
      mac_clr     <= 1'b0;
      ram_en      <= 1'b0;
      ram_wen     <= 1'b0;
      busy        <= 1'b0;
      eoc         <= 1'b0;
    end else begin
      index_start <= index_start_d;
      mac_en      <= mac_en_d;
      mac_clr     <= mac_clr_d;
      ram_en      <= ram_en_d;
      ram_wen     <= ram_en_d;
      busy        <= busy_d;
      eoc         <= eoc_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST || abort || state != DRAIN) begin
      drain_cnt <= '0;
    end else begin
      drain_cnt <= drain_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST || abort) begin
      pix_idx <= '0;
    end else if (state == SAVE) begin
      pix_idx <= last_pix ? '0 : pix_idx + 1'b1;
    end
  end

endmodule
